// File: rtl/mips_cpu_muldiv_ctrl.sv
// HI/LO owner for the MIPS mul/div unit: sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO
// with a shift-add multiplier (optionally single-step) and a 32-step restoring divider.
module mips_cpu_muldiv_ctrl #(
    parameter bit FAST_MUL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mf_read,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall
);
    // state | meaning
    // IDLE  | accepting ops; MTHI/MTLO and divide-by-zero finish here
    // CALC  | one multiply or divide iteration per edge, counter 0..31
    // FIX   | sign correction and HI/LO write, then back to IDLE
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam logic [2:0] OP_MULTU = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_t      state;
    logic [4:0]  counter;
    logic [63:0] acc;       // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [31:0] opnd;      // multiplicand or divisor magnitude
    logic        is_div;
    logic        neg_prod;  // product sign, also the quotient sign
    logic        neg_rem;

    logic [31:0] a_mag, b_mag;
    logic [63:0] fast_prod;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] rem_sh;
    logic [33:0] diff;
    logic [63:0] div_next;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    // op[0] marks the signed variants of both multiply and divide
    always_comb begin
        a_mag     = (op[0] && a[31]) ? (~a + 32'd1) : a;
        b_mag     = (op[0] && b[31]) ? (~b + 32'd1) : b;
        fast_prod = {32'd0, a_mag} * {32'd0, b_mag};
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        mul_next  = {mul_sum, acc[31:1]};
        rem_sh    = {acc[63:32], acc[31]};
        diff      = {1'b0, rem_sh} - {2'd0, opnd};
        div_next  = diff[33] ? {rem_sh[31:0], acc[30:0], 1'b0}
                             : {diff[31:0],   acc[30:0], 1'b1};
        prod_fix  = neg_prod ? (~acc + 64'd1) : acc;
        quo_fix   = neg_prod ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem_fix   = neg_rem  ? (~acc[63:32] + 32'd1) : acc[63:32];
    end

    assign stall = busy & (start | mf_read);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            counter  <= 5'd0;
            acc      <= 64'd0;
            opnd     <= 32'd0;
            is_div   <= 1'b0;
            neg_prod <= 1'b0;
            neg_rem  <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            OP_MULTU, OP_MULT: begin
                                opnd     <= a_mag;
                                is_div   <= 1'b0;
                                neg_prod <= op[0] & (a[31] ^ b[31]);
                                neg_rem  <= op[0] & a[31];
                                counter  <= 5'd0;
                                busy     <= 1'b1;
                                if (FAST_MUL) begin
                                    acc   <= fast_prod;
                                    state <= FIX;
                                end else begin
                                    acc   <= {32'd0, b_mag};
                                    state <= CALC;
                                end
                            end
                            OP_DIVU, OP_DIV: begin
                                if (b == 32'd0) begin
                                    done <= 1'b1;
                                end else begin
                                    acc      <= {32'd0, a_mag};
                                    opnd     <= b_mag;
                                    is_div   <= 1'b1;
                                    neg_prod <= op[0] & (a[31] ^ b[31]);
                                    neg_rem  <= op[0] & a[31];
                                    counter  <= 5'd0;
                                    busy     <= 1'b1;
                                    state    <= CALC;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    acc     <= is_div ? div_next : mul_next;
                    counter <= counter + 5'd1;
                    if (counter == 5'd31)
                        state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
